// File: rtl/bus_rr.sv
// bus_rr: shared-bus interconnect with device back-pressure, an in-order
// outstanding-transaction tracker and error responses for unmapped addresses.
// Optional macro BUS_ROUND_ROBIN_EN selects round-robin arbitration; when it is
// undefined the lowest requesting host index always wins.
module bus_rr #(
    parameter int unsigned NrHosts        = 3,
    parameter int unsigned NrDevices      = 2,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddressWidth   = 32,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      host_req_i           [NrHosts],
    output logic                      host_gnt_o           [NrHosts],
    input  logic [AddressWidth-1:0]   host_addr_i          [NrHosts],
    input  logic                      host_we_i            [NrHosts],
    input  logic [DataWidth/8-1:0]    host_be_i            [NrHosts],
    input  logic [DataWidth-1:0]      host_wdata_i         [NrHosts],
    output logic                      host_rvalid_o        [NrHosts],
    output logic [DataWidth-1:0]      host_rdata_o         [NrHosts],
    output logic                      host_err_o           [NrHosts],
    output logic                      device_req_o         [NrDevices],
    input  logic                      device_gnt_i         [NrDevices],
    output logic [AddressWidth-1:0]   device_addr_o        [NrDevices],
    output logic                      device_we_o          [NrDevices],
    output logic [DataWidth/8-1:0]    device_be_o          [NrDevices],
    output logic [DataWidth-1:0]      device_wdata_o       [NrDevices],
    input  logic                      device_rvalid_i      [NrDevices],
    input  logic [DataWidth-1:0]      device_rdata_i       [NrDevices],
    input  logic                      device_err_i         [NrDevices],
    input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
    input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices]
);

    localparam int unsigned BeWidth = DataWidth / 8;
    localparam int unsigned HostW   = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int unsigned TgtW    = $clog2(NrDevices + 1);
    localparam int unsigned PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW    = $clog2(MaxOutstanding + 1);
    // Target code one past the last device marks a decode-error entry.
    localparam logic [TgtW-1:0] ErrTgt = TgtW'(NrDevices);

    logic [HostW-1:0]        ptr;
    logic                    win_valid;
    logic [HostW-1:0]        win_host;
    logic [AddressWidth-1:0] win_addr;
    logic                    win_we;
    logic [BeWidth-1:0]      win_be;
    logic [DataWidth-1:0]    win_wdata;
    logic [TgtW-1:0]         win_tgt;
    logic                    win_err;
    logic                    tgt_gnt;
    logic                    slot_ok;
    logic                    grant;

    logic [HostW-1:0]        trk_host [MaxOutstanding];
    logic [TgtW-1:0]         trk_tgt  [MaxOutstanding];
    logic                    trk_err  [MaxOutstanding];
    logic [PtrW-1:0]         wr_ptr;
    logic [PtrW-1:0]         rd_ptr;
    logic [CntW-1:0]         count;
    logic [TgtW-1:0]         last_tgt;
    logic                    trk_empty;
    logic                    trk_full;

    logic [HostW-1:0]        head_host;
    logic [TgtW-1:0]         head_tgt;
    logic                    head_err;
    logic                    head_rvalid;
    logic [DataWidth-1:0]    head_rdata;
    logic                    head_rerr;
    logic                    pop_dev;
    logic                    pop_err;
    logic                    pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (32'(p) == MaxOutstanding - 1) ? '0 : p + PtrW'(1);
    endfunction

    // Pick one requesting host, searching upward from ptr and wrapping.
    always_comb begin
        win_valid = 1'b0;
        win_host  = '0;
        for (int unsigned h = 0; h < NrHosts; h++) begin
            if (!win_valid && host_req_i[h] && h >= 32'(ptr)) begin
                win_valid = 1'b1;
                win_host  = HostW'(h);
            end
        end
        for (int unsigned h = 0; h < NrHosts; h++) begin
            if (!win_valid && host_req_i[h] && h < 32'(ptr)) begin
                win_valid = 1'b1;
                win_host  = HostW'(h);
            end
        end
    end

    // Winner's request fields.
    always_comb begin
        win_addr  = '0;
        win_we    = 1'b0;
        win_be    = '0;
        win_wdata = '0;
        for (int unsigned h = 0; h < NrHosts; h++) begin
            if (win_host == HostW'(h)) begin
                win_addr  = host_addr_i[h];
                win_we    = host_we_i[h];
                win_be    = host_be_i[h];
                win_wdata = host_wdata_i[h];
            end
        end
    end

    // Address decode: lowest matching device index wins, none is an error.
    always_comb begin
        win_tgt = ErrTgt;
        for (int unsigned d = 0; d < NrDevices; d++) begin
            if (win_tgt == ErrTgt &&
                (win_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) begin
                win_tgt = TgtW'(d);
            end
        end
    end

    assign win_err = (win_tgt == ErrTgt);

    // Back-pressure of the selected device.
    always_comb begin
        tgt_gnt = 1'b0;
        for (int unsigned d = 0; d < NrDevices; d++) begin
            if (win_tgt == TgtW'(d)) tgt_gnt = device_gnt_i[d];
        end
    end

    assign trk_empty = (count == '0);
    assign trk_full  = (count == CntW'(MaxOutstanding));
    // Tracker can take the winner: room left and no reordering across targets.
    assign slot_ok   = !rst_i && win_valid && !trk_full && (trk_empty || last_tgt == win_tgt);
    assign grant     = slot_ok && (win_err || tgt_gnt);

    // Forward the winner to its device; held while only device back-pressure blocks.
    always_comb begin
        for (int unsigned d = 0; d < NrDevices; d++) begin
            device_req_o[d]   = 1'b0;
            device_addr_o[d]  = '0;
            device_we_o[d]    = 1'b0;
            device_be_o[d]    = '0;
            device_wdata_o[d] = '0;
            if (slot_ok && win_tgt == TgtW'(d)) begin
                device_req_o[d]   = 1'b1;
                device_addr_o[d]  = win_addr;
                device_we_o[d]    = win_we;
                device_be_o[d]    = win_be;
                device_wdata_o[d] = win_wdata;
            end
        end
    end

    assign head_host = trk_host[rd_ptr];
    assign head_tgt  = trk_tgt[rd_ptr];
    assign head_err  = trk_err[rd_ptr];

    // Response signals of the device owning the oldest entry.
    always_comb begin
        head_rvalid = 1'b0;
        head_rdata  = '0;
        head_rerr   = 1'b0;
        for (int unsigned d = 0; d < NrDevices; d++) begin
            if (head_tgt == TgtW'(d)) begin
                head_rvalid = device_rvalid_i[d];
                head_rdata  = device_rdata_i[d];
                head_rerr   = device_err_i[d];
            end
        end
    end

    assign pop_dev = !trk_empty && !head_err && head_rvalid;
    assign pop_err = !trk_empty && head_err;
    assign pop     = pop_dev || pop_err;

    // Host-side grant and response routing.
    always_comb begin
        for (int unsigned h = 0; h < NrHosts; h++) begin
            host_gnt_o[h]    = grant && (win_host == HostW'(h));
            host_rvalid_o[h] = 1'b0;
            host_rdata_o[h]  = '0;
            host_err_o[h]    = 1'b0;
            if (pop && head_host == HostW'(h)) begin
                host_rvalid_o[h] = 1'b1;
                host_rdata_o[h]  = pop_dev ? head_rdata : '0;
                host_err_o[h]    = pop_err ? 1'b1 : head_rerr;
            end
        end
    end

    // Tracker pointers, occupancy and most recently pushed target.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_tgt <= '0;
        end else begin
            if (grant) begin
                wr_ptr   <= next_ptr(wr_ptr);
                last_tgt <= win_tgt;
            end
            if (pop) rd_ptr <= next_ptr(rd_ptr);
            if (grant && !pop)      count <= count + CntW'(1);
            else if (pop && !grant) count <= count - CntW'(1);
        end
    end

    // Tracker entry storage; validity is carried by the pointers.
    always_ff @(posedge clk_i) begin
        if (grant) begin
            trk_host[wr_ptr] <= win_host;
            trk_tgt[wr_ptr]  <= win_tgt;
            trk_err[wr_ptr]  <= win_err;
        end
    end

`ifdef BUS_ROUND_ROBIN_EN
    // Priority pointer moves just past the last granted host.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)      ptr <= '0;
        else if (grant) ptr <= (32'(win_host) == NrHosts - 1) ? '0 : win_host + HostW'(1);
    end
`else
    assign ptr = '0;
`endif

`ifndef SYNTHESIS
    // A device response is only legal for the oldest outstanding entry.
    for (genvar d = 0; d < NrDevices; d++) begin : g_proto_chk
        a_rvalid_head : assert property (@(posedge clk_i) disable iff (rst_i)
            device_rvalid_i[d] |-> (!trk_empty && !head_err && head_tgt == TgtW'(d)));
    end
`endif

endmodule

// File: tb/tb_bus_rr.sv
// tb_bus_rr: directed scenarios plus randomized traffic against a queue-based model.
module tb_bus_rr;

    localparam int NH   = 3;
    localparam int ND   = 2;
    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int MO   = 4;
    localparam int RAM  = 0;
    localparam int UTIL = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          host_req    [NH];
    logic          host_gnt    [NH];
    logic [AW-1:0] host_addr   [NH];
    logic          host_we     [NH];
    logic [3:0]    host_be     [NH];
    logic [DW-1:0] host_wdata  [NH];
    logic          host_rvalid [NH];
    logic [DW-1:0] host_rdata  [NH];
    logic          host_err    [NH];
    logic          dev_req     [ND];
    logic          dev_gnt     [ND];
    logic [AW-1:0] dev_addr    [ND];
    logic          dev_we      [ND];
    logic [3:0]    dev_be      [ND];
    logic [DW-1:0] dev_wdata   [ND];
    logic          dev_rvalid  [ND];
    logic [DW-1:0] dev_rdata   [ND];
    logic          dev_err     [ND];
    logic [AW-1:0] cfg_base    [ND];
    logic [AW-1:0] cfg_mask    [ND];

    int total = 0;
    int bad   = 0;

    typedef struct {
        int host;
        int tgt;
    } ent_t;

    bus_rr #(
        .NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .host_req_i(host_req), .host_gnt_o(host_gnt), .host_addr_i(host_addr),
        .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
        .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
        .device_req_o(dev_req), .device_gnt_i(dev_gnt), .device_addr_o(dev_addr),
        .device_we_o(dev_we), .device_be_o(dev_be), .device_wdata_o(dev_wdata),
        .device_rvalid_i(dev_rvalid), .device_rdata_i(dev_rdata), .device_err_i(dev_err),
        .cfg_device_addr_base(cfg_base), .cfg_device_addr_mask(cfg_mask)
    );

    always #5 clk = ~clk;

    function automatic logic [NH-1:0] gnt_vec();
        logic [NH-1:0] v;
        for (int h = 0; h < NH; h++) v[h] = host_gnt[h];
        return v;
    endfunction

    function automatic logic [NH-1:0] rvalid_vec();
        logic [NH-1:0] v;
        for (int h = 0; h < NH; h++) v[h] = host_rvalid[h];
        return v;
    endfunction

    function automatic logic [NH-1:0] err_vec();
        logic [NH-1:0] v;
        for (int h = 0; h < NH; h++) v[h] = host_err[h];
        return v;
    endfunction

    function automatic logic [ND-1:0] dreq_vec();
        logic [ND-1:0] v;
        for (int d = 0; d < ND; d++) v[d] = dev_req[d];
        return v;
    endfunction

    function automatic int decode(input logic [AW-1:0] a);
        for (int d = 0; d < ND; d++) begin
            if ((a & cfg_mask[d]) == cfg_base[d]) return d;
        end
        return -1;
    endfunction

    task automatic idle_inputs();
        for (int h = 0; h < NH; h++) begin
            host_req[h] = 1'b0; host_addr[h] = '0; host_we[h] = 1'b0;
            host_be[h] = '0; host_wdata[h] = '0;
        end
        for (int d = 0; d < ND; d++) begin
            dev_gnt[d] = 1'b0; dev_rvalid[d] = 1'b0; dev_rdata[d] = '0; dev_err[d] = 1'b0;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        for (int h = 0; h < NH; h++) begin
            host_req[h] = 1'b1; host_addr[h] = 32'h0000_0100;
        end
        for (int d = 0; d < ND; d++) dev_gnt[d] = 1'b1;
        @(negedge clk);
        total++; if (gnt_vec() !== '0) begin bad++; $display("FAIL reset_gnt got=%b exp=000", gnt_vec()); end
        total++; if (rvalid_vec() !== '0) begin bad++; $display("FAIL reset_rvalid got=%b exp=000", rvalid_vec()); end
        total++; if (err_vec() !== '0) begin bad++; $display("FAIL reset_err got=%b exp=000", err_vec()); end
        total++; if (dreq_vec() !== '0) begin bad++; $display("FAIL reset_dreq got=%b exp=00", dreq_vec()); end
        for (int h = 0; h < NH; h++) begin
            total++;
            if (host_rdata[h] !== '0) begin
                bad++; $display("FAIL reset_rdata[%0d] got=%h exp=0", h, host_rdata[h]);
            end
        end
        next_cycle();
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_round_robin();
        logic [NH-1:0] exp;
        int exp_h;
        int prev_h = 0;
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            for (int h = 0; h < NH; h++) begin
                host_req[h] = 1'b1; host_addr[h] = 32'h0000_0040 + 32'(h * 4); host_we[h] = 1'b0;
            end
            dev_gnt[RAM]    = 1'b1;
            dev_rvalid[RAM] = (c > 0);
            dev_rdata[RAM]  = 32'hA000_0000 + 32'(c);
`ifdef BUS_ROUND_ROBIN_EN
            exp_h = c % NH;
`else
            exp_h = 0;
`endif
            @(negedge clk);
            exp = '0; exp[exp_h] = 1'b1;
            total++;
            if (gnt_vec() !== exp) begin
                bad++; $display("FAIL rr_gnt cycle %0d got=%b exp=%b", c, gnt_vec(), exp);
            end
            if (c > 0) begin
                total++;
                if (host_rvalid[prev_h] !== 1'b1 || host_rdata[prev_h] !== 32'hA000_0000 + 32'(c)) begin
                    bad++; $display("FAIL rr_resp cycle %0d got=%b/%h exp=1/%h", c,
                                    host_rvalid[prev_h], host_rdata[prev_h], 32'hA000_0000 + 32'(c));
                end
            end
            prev_h = exp_h;
            next_cycle();
        end
        idle_inputs();
        dev_rvalid[RAM] = 1'b1;
        dev_rdata[RAM]  = 32'hA000_00FF;
        @(negedge clk);
        exp = '0; exp[prev_h] = 1'b1;
        total++;
        if (rvalid_vec() !== exp || host_rdata[prev_h] !== 32'hA000_00FF) begin
            bad++; $display("FAIL rr_drain got=%b/%h exp=%b/a00000ff", rvalid_vec(), host_rdata[prev_h], exp);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_decode_error();
        apply_reset();
        host_req[1] = 1'b1; host_addr[1] = 32'h0003_0000; host_we[1] = 1'b0;
        dev_gnt[RAM] = 1'b1; dev_gnt[UTIL] = 1'b1;
        @(negedge clk);
        total++; if (gnt_vec() !== 3'b010) begin bad++; $display("FAIL derr_gnt got=%b exp=010", gnt_vec()); end
        total++; if (dreq_vec() !== 2'b00) begin bad++; $display("FAIL derr_dreq got=%b exp=00", dreq_vec()); end
        total++; if (rvalid_vec() !== 3'b000) begin bad++; $display("FAIL derr_early got=%b exp=000", rvalid_vec()); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        total++; if (rvalid_vec() !== 3'b010) begin bad++; $display("FAIL derr_rvalid got=%b exp=010", rvalid_vec()); end
        total++; if (host_err[1] !== 1'b1) begin bad++; $display("FAIL derr_err got=%b exp=1", host_err[1]); end
        total++; if (host_rdata[1] !== '0) begin bad++; $display("FAIL derr_rdata got=%h exp=0", host_rdata[1]); end
        next_cycle();
        @(negedge clk);
        total++; if (rvalid_vec() !== 3'b000) begin bad++; $display("FAIL derr_once got=%b exp=000", rvalid_vec()); end
        next_cycle();
    endtask

    task automatic test_tracker_full();
        apply_reset();
        host_req[0] = 1'b1; host_addr[0] = 32'h0000_0200; host_we[0] = 1'b0;
        dev_gnt[RAM] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (host_gnt[0] !== (c < MO)) begin
                bad++; $display("FAIL full_gnt cycle %0d got=%b exp=%b", c, host_gnt[0], (c < MO));
            end
            next_cycle();
        end
        dev_rvalid[RAM] = 1'b1; dev_rdata[RAM] = 32'h5555_0001;
        @(negedge clk);
        total++; if (host_gnt[0] !== 1'b0) begin bad++; $display("FAIL full_pop_gnt got=%b exp=0", host_gnt[0]); end
        total++;
        if (host_rvalid[0] !== 1'b1 || host_rdata[0] !== 32'h5555_0001) begin
            bad++; $display("FAIL full_pop_resp got=%b/%h exp=1/55550001", host_rvalid[0], host_rdata[0]);
        end
        next_cycle();
        dev_rvalid[RAM] = 1'b0;
        @(negedge clk);
        total++; if (host_gnt[0] !== 1'b1) begin bad++; $display("FAIL full_fifth_gnt got=%b exp=1", host_gnt[0]); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_cross_device();
        apply_reset();
        host_req[2] = 1'b1; host_addr[2] = 32'h0000_0080; host_we[2] = 1'b0;
        dev_gnt[RAM] = 1'b1; dev_gnt[UTIL] = 1'b1;
        @(negedge clk);
        total++; if (gnt_vec() !== 3'b100) begin bad++; $display("FAIL xdev_ram_gnt got=%b exp=100", gnt_vec()); end
        next_cycle();
        host_req[2] = 1'b0;
        host_req[1] = 1'b1; host_addr[1] = 32'h0002_0000; host_we[1] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if (gnt_vec() !== 3'b000) begin bad++; $display("FAIL xdev_block cycle %0d got=%b exp=000", c, gnt_vec()); end
            next_cycle();
        end
        dev_rvalid[RAM] = 1'b1; dev_rdata[RAM] = 32'h1234_5678;
        @(negedge clk);
        total++; if (gnt_vec() !== 3'b000) begin bad++; $display("FAIL xdev_pop_gnt got=%b exp=000", gnt_vec()); end
        total++;
        if (rvalid_vec() !== 3'b100 || host_rdata[2] !== 32'h1234_5678) begin
            bad++; $display("FAIL xdev_ram_resp got=%b/%h exp=100/12345678", rvalid_vec(), host_rdata[2]);
        end
        next_cycle();
        dev_rvalid[RAM] = 1'b0;
        @(negedge clk);
        total++; if (gnt_vec() !== 3'b010) begin bad++; $display("FAIL xdev_util_gnt got=%b exp=010", gnt_vec()); end
        total++; if (dreq_vec() !== 2'b10) begin bad++; $display("FAIL xdev_util_dreq got=%b exp=10", dreq_vec()); end
        next_cycle();
        idle_inputs();
        dev_rvalid[UTIL] = 1'b1; dev_rdata[UTIL] = 32'hCAFE_0001;
        @(negedge clk);
        total++;
        if (rvalid_vec() !== 3'b010 || host_rdata[1] !== 32'hCAFE_0001 || host_err[1] !== 1'b0) begin
            bad++; $display("FAIL xdev_util_resp got=%b/%h exp=010/cafe0001", rvalid_vec(), host_rdata[1]);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_back_pressure();
        apply_reset();
        host_req[0] = 1'b1; host_addr[0] = 32'h0000_0010; host_we[0] = 1'b1;
        host_be[0] = 4'hF; host_wdata[0] = 32'hDEAD_BEEF;
        for (int c = 0; c < 4; c++) begin
            dev_gnt[RAM] = (c == 3);
            @(negedge clk);
            total++;
            if (host_gnt[0] !== (c == 3)) begin
                bad++; $display("FAIL bp_gnt cycle %0d got=%b exp=%b", c, host_gnt[0], (c == 3));
            end
            total++;
            if (dreq_vec() !== 2'b01 || dev_addr[RAM] !== 32'h0000_0010 || dev_we[RAM] !== 1'b1 ||
                dev_be[RAM] !== 4'hF || dev_wdata[RAM] !== 32'hDEAD_BEEF) begin
                bad++; $display("FAIL bp_fields cycle %0d got=%b/%h/%b/%h/%h exp=01/00000010/1/f/deadbeef",
                                c, dreq_vec(), dev_addr[RAM], dev_we[RAM], dev_be[RAM], dev_wdata[RAM]);
            end
            next_cycle();
        end
        idle_inputs();
        dev_rvalid[RAM] = 1'b1;
        @(negedge clk);
        total++;
        if (rvalid_vec() !== 3'b001 || host_err[0] !== 1'b0) begin
            bad++; $display("FAIL bp_resp got=%b/%b exp=001/0", rvalid_vec(), host_err[0]);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        host_req[0] = 1'b1; host_addr[0] = 32'h0000_0300; host_we[0] = 1'b0;
        dev_gnt[RAM] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++; if (gnt_vec() !== 3'b001) begin bad++; $display("FAIL rmid_pre_gnt cycle %0d got=%b exp=001", c, gnt_vec()); end
            next_cycle();
        end
        rst = 1'b1;
        @(negedge clk);
        total++; if (gnt_vec() !== 3'b000) begin bad++; $display("FAIL rmid_gnt got=%b exp=000", gnt_vec()); end
        total++; if (dreq_vec() !== 2'b00) begin bad++; $display("FAIL rmid_dreq got=%b exp=00", dreq_vec()); end
        total++; if (rvalid_vec() !== 3'b000) begin bad++; $display("FAIL rmid_rvalid got=%b exp=000", rvalid_vec()); end
        next_cycle();
        rst = 1'b0;
        idle_inputs();
        host_req[1] = 1'b1; host_addr[1] = 32'h0002_0004; host_we[1] = 1'b0;
        dev_gnt[UTIL] = 1'b1;
        @(negedge clk);
        total++; if (gnt_vec() !== 3'b010) begin bad++; $display("FAIL rmid_fresh_gnt got=%b exp=010", gnt_vec()); end
        next_cycle();
        idle_inputs();
        dev_rvalid[UTIL] = 1'b1; dev_rdata[UTIL] = 32'hBEEF_0003;
        @(negedge clk);
        total++;
        if (rvalid_vec() !== 3'b010 || host_rdata[1] !== 32'hBEEF_0003) begin
            bad++; $display("FAIL rmid_fresh_resp got=%b/%h exp=010/beef0003", rvalid_vec(), host_rdata[1]);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        total++; if (rvalid_vec() !== 3'b000) begin bad++; $display("FAIL rmid_stale got=%b exp=000", rvalid_vec()); end
        next_cycle();
    endtask

    task automatic test_random();
        ent_t q[$];
        int   mptr = 0;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            logic [NH-1:0] exp_gnt;
            logic [ND-1:0] exp_dreq;
            logic [NH-1:0] exp_rv;
            logic [DW-1:0] exp_rd;
            logic          exp_er;
            int  win, tgt, rh, sel;
            bit  room, pop;
            // Stimulus for this cycle.
            for (int h = 0; h < NH; h++) begin
                host_req[h] = ($urandom_range(0, 99) < 60);
                sel = $urandom_range(0, 9);
                if (sel < 5)      host_addr[h] = 32'h0000_0000 | ($urandom & 32'h0000_FFFC);
                else if (sel < 8) host_addr[h] = 32'h0002_0000 | ($urandom & 32'h0000_FFFC);
                else              host_addr[h] = 32'h0003_0000 | ($urandom & 32'h0000_FFFC);
                host_we[h]    = 1'($urandom);
                host_be[h]    = 4'($urandom);
                host_wdata[h] = $urandom;
            end
            for (int d = 0; d < ND; d++) begin
                dev_gnt[d]    = ($urandom_range(0, 3) != 0);
                dev_rvalid[d] = 1'b0;
                dev_rdata[d]  = $urandom;
                dev_err[d]    = ($urandom_range(0, 3) == 0);
            end
            if (q.size() > 0 && q[0].tgt >= 0 && $urandom_range(0, 1) == 1) dev_rvalid[q[0].tgt] = 1'b1;
            @(negedge clk);
            // Reference: arbitration, admission and response.
            win = -1;
            for (int k = 0; k < NH; k++) begin
                if (win < 0 && host_req[(mptr + k) % NH]) win = (mptr + k) % NH;
            end
            exp_gnt = '0; exp_dreq = '0; tgt = -1; room = 1'b0;
            if (win >= 0) begin
                tgt  = decode(host_addr[win]);
                room = (q.size() < MO) && (q.size() == 0 || q[$].tgt == tgt);
                if (room && (tgt < 0 || dev_gnt[tgt])) exp_gnt[win] = 1'b1;
                if (room && tgt >= 0) exp_dreq[tgt] = 1'b1;
            end
            exp_rv = '0; exp_rd = '0; exp_er = 1'b0; rh = -1; pop = 1'b0;
            if (q.size() > 0) begin
                if (q[0].tgt < 0) begin
                    rh = q[0].host; exp_er = 1'b1; pop = 1'b1;
                end else if (dev_rvalid[q[0].tgt]) begin
                    rh = q[0].host; exp_rd = dev_rdata[q[0].tgt]; exp_er = dev_err[q[0].tgt]; pop = 1'b1;
                end
            end
            if (rh >= 0) exp_rv[rh] = 1'b1;
            total++;
            if (gnt_vec() !== exp_gnt) begin
                bad++; $display("FAIL rand_gnt cycle %0d got=%b exp=%b", c, gnt_vec(), exp_gnt);
            end
            total++;
            if (rvalid_vec() !== exp_rv) begin
                bad++; $display("FAIL rand_rvalid cycle %0d got=%b exp=%b", c, rvalid_vec(), exp_rv);
            end
            if (rh >= 0) begin
                total++;
                if (host_rdata[rh] !== exp_rd || host_err[rh] !== exp_er) begin
                    bad++; $display("FAIL rand_resp cycle %0d host %0d got=%h/%b exp=%h/%b",
                                    c, rh, host_rdata[rh], host_err[rh], exp_rd, exp_er);
                end
            end
            if (win < 0 || room) begin
                total++;
                if (dreq_vec() !== exp_dreq) begin
                    bad++; $display("FAIL rand_dreq cycle %0d got=%b exp=%b", c, dreq_vec(), exp_dreq);
                end
            end
            if (win >= 0 && room && tgt >= 0) begin
                total++;
                if (dev_addr[tgt] !== host_addr[win] || dev_we[tgt] !== host_we[win] ||
                    dev_be[tgt] !== host_be[win] || dev_wdata[tgt] !== host_wdata[win] ||
                    dev_addr[1 - tgt] !== '0 || dev_wdata[1 - tgt] !== '0) begin
                    bad++; $display("FAIL rand_fields cycle %0d dev %0d got=%h/%h exp=%h/%h", c, tgt,
                                    dev_addr[tgt], dev_wdata[tgt], host_addr[win], host_wdata[win]);
                end
            end
            // Advance the reference at the coming clock edge.
            if (pop) void'(q.pop_front());
            if (exp_gnt != '0) begin
                q.push_back('{host: win, tgt: tgt});
`ifdef BUS_ROUND_ROBIN_EN
                mptr = (win + 1) % NH;
`endif
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        cfg_base[RAM]  = 32'h0000_0000; cfg_mask[RAM]  = 32'hFFFF_0000;
        cfg_base[UTIL] = 32'h0002_0000; cfg_mask[UTIL] = 32'hFFFF_0000;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_round_robin();
        test_decode_error();
        test_tracker_full();
        test_cross_device();
        test_back_pressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
